// File: rtl/chdr_hdr_strip.sv
// chdr_hdr_strip: strips the CVITA header (and optional timestamp) beats
// from a packet stream, forwards the payload with zero latency, exposes the
// decoded header as sideband, and flags length / sequence-number errors.
module chdr_hdr_strip #(
  parameter bit SEQ_CHECK = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  // CVITA packet stream in
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  // payload stream out
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  // header sideband for the current packet
  output logic [1:0]       o_pkt_type,
  output logic             o_has_time,
  output logic             o_eob,
  output logic [11:0]      o_seqnum,
  output logic [15:0]      o_length,
  output logic [15:0]      o_src_sid,
  output logic [15:0]      o_dst_sid,
  output logic [63:0]      o_timestamp,
  // pulses and status
  output logic             hdr_only,
  output logic             err_len,
  output logic             err_seq,
  output logic [CNT_W-1:0] pkt_count,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {S_HDR, S_TIME, S_BODY} state_t;

  state_t      state, state_nxt;
  logic        in_body;
  logic        accept;
  logic        acc_last;
  logic [13:0] beat_cnt;   // beats accepted so far in the current packet
  logic [13:0] beat_w;     // beat count including the current beat
  logic [15:0] len_cur;
  logic [16:0] len_bytes;
  logic        len_ok;
  logic [11:0] seq_exp;
  logic        seq_vld;
  logic        seq_bad;

  // Payload data is a plain wire; qualifiers below decide whether it counts.
  assign o_tdata = i_tdata;

  // Stream muxing and next-state decode; reset forces the header-consume view
  // combinationally so the streams go quiet without waiting for a clock.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_body   = (state == S_BODY) && reset_n;
    i_tready  = in_body ? o_tready : 1'b1;
    o_tvalid  = in_body && i_tvalid;
    o_tlast   = in_body && i_tlast;
    accept    = i_tvalid && i_tready;
    acc_last  = accept && i_tlast;
    if (accept) begin
      case (state)
        S_HDR:   state_nxt = i_tlast ? S_HDR : (i_tdata[61] ? S_TIME : S_BODY);
        S_TIME:  state_nxt = i_tlast ? S_HDR : S_BODY;
        S_BODY:  state_nxt = i_tlast ? S_HDR : S_BODY;
        default: state_nxt = S_HDR;
      endcase
    end
  end

  // Length check: a packet of w beats must carry 8*w or 8*w-4 bytes. On a
  // header-only packet the length is still on the bus, not yet registered.
  always_comb begin
    beat_w    = (beat_cnt == 14'h3FFF) ? beat_cnt : beat_cnt + 14'd1;
    len_cur   = (state == S_HDR) ? i_tdata[47:32] : o_length;
    len_bytes = {beat_w, 3'b000};
    len_ok    = ({1'b0, len_cur} == len_bytes) ||
                ({1'b0, len_cur} == len_bytes - 17'd4);
    seq_bad   = SEQ_CHECK && seq_vld && (i_tdata[59:48] != seq_exp);
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_HDR;
    else          state <= state_nxt;
  end

  // Header and timestamp capture; fields hold until the next header.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_pkt_type  <= '0;
      o_has_time  <= 1'b0;
      o_eob       <= 1'b0;
      o_seqnum    <= '0;
      o_length    <= '0;
      o_src_sid   <= '0;
      o_dst_sid   <= '0;
      o_timestamp <= '0;
    end else if (accept && state == S_HDR) begin
      o_pkt_type <= i_tdata[63:62];
      o_has_time <= i_tdata[61];
      o_eob      <= i_tdata[60];
      o_seqnum   <= i_tdata[59:48];
      o_length   <= i_tdata[47:32];
      o_src_sid  <= i_tdata[31:16];
      o_dst_sid  <= i_tdata[15:0];
      if (!i_tdata[61]) o_timestamp <= '0;
    end else if (accept && state == S_TIME) begin
      o_timestamp <= i_tdata;
    end
  end

  // Per-packet beat counter (saturating) and sequence-number tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      seq_exp  <= '0;
      seq_vld  <= 1'b0;
    end else if (accept) begin
      beat_cnt <= i_tlast ? 14'd0 : beat_w;
      if (state == S_HDR) begin
        seq_exp <= i_tdata[59:48] + 12'd1;
        seq_vld <= 1'b1;
      end
    end
  end

  // Registered pulses, one cycle after the triggering beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_len  <= 1'b0;
      err_seq  <= 1'b0;
      hdr_only <= 1'b0;
    end else begin
      err_len  <= acc_last && !len_ok;
      err_seq  <= accept && (state == S_HDR) && seq_bad;
      hdr_only <= acc_last && (state != S_BODY);
    end
  end

  // Status counters: packets wrap, errors saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (acc_last) pkt_count <= pkt_count + CNT_W'(1);
      if ((err_len || err_seq) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_chdr_hdr_strip.sv
// tb_chdr_hdr_strip: packet-level bench with a payload scoreboard, a table of
// packet vectors and hand-written sequences for seqnum wrap and mid-packet reset.
module tb_chdr_hdr_strip;

  logic        clk, reset_n;
  logic [63:0] i_tdata, o_tdata, o_timestamp;
  logic        i_tlast, i_tvalid, i_tready;
  logic        o_tlast, o_tvalid, o_tready;
  logic [1:0]  o_pkt_type;
  logic        o_has_time, o_eob;
  logic [11:0] o_seqnum;
  logic [15:0] o_length, o_src_sid, o_dst_sid;
  logic        hdr_only, err_len, err_seq;
  logic [31:0] pkt_count;
  logic [15:0] err_count;

  chdr_hdr_strip #(.SEQ_CHECK(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_pkt_type(o_pkt_type), .o_has_time(o_has_time), .o_eob(o_eob),
    .o_seqnum(o_seqnum), .o_length(o_length), .o_src_sid(o_src_sid),
    .o_dst_sid(o_dst_sid), .o_timestamp(o_timestamp),
    .hdr_only(hdr_only), .err_len(err_len), .err_seq(err_seq),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  typedef struct {
    logic [11:0] seq;
    bit          ht;
    logic [63:0] ts;
    logic [15:0] len;
    logic [63:0] base;
    int          npay;
    int          e_len;
    int          e_hdr;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   n_len = 0, n_seq = 0, n_hdr = 0;
  bit   rand_en = 0;
  logic [64:0] sb[$];   // {tlast, tdata} expected on the payload port

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Payload monitor and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_len)  n_len++;
    if (err_seq)  n_seq++;
    if (hdr_only) n_hdr++;
    if (o_tvalid && o_tready) begin
      if (sb.size() == 0) check("extra_payload", {63'd0, o_tlast}, 64'h1);
      else begin
        logic [64:0] e;
        e = sb.pop_front();
        check("payload_data", o_tdata, e[63:0]);
        check("payload_last", {63'd0, o_tlast}, {63'd0, e[64]});
      end
    end
  end

  // Random downstream backpressure.
  initial begin
    o_tready = 1;
    forever begin
      @(posedge clk); #1;
      if (rand_en) o_tready = ($urandom_range(0, 9) < 6);
    end
  end

  function automatic logic [63:0] hdr(input logic [11:0] seq, input bit ht, input logic [15:0] len);
    return {2'b00, ht, 1'b0, seq, len, 16'h1234, 16'h5678};
  endfunction

  task automatic send_beat(input logic [63:0] d, input bit last, input bit fwd);
    bit ok = 0;
    if (fwd) sb.push_back({last, d});
    i_tdata = d; i_tlast = last; i_tvalid = 1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (i_tready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    i_tvalid = 0; i_tdata = 64'hDEAD_BEEF_DEAD_BEEF; i_tlast = 1;
    if (!ok) check("tx_timeout", 64'd0, 64'd1);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input logic [11:0] seq, input bit ht, input logic [63:0] ts,
                          input logic [15:0] len, input logic [63:0] base, input int npay);
    send_beat(hdr(seq, ht, len), (npay == 0) && !ht, 1'b0);
    if (ht) send_beat(ts, npay == 0, 1'b0);
    for (int k = 0; k < npay; k++) send_beat(base + 64'(k), k == npay - 1, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin @(posedge clk); #1; n++; end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 0;
    #12;
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[6];
    int   l0, s0, h0;
    int   exp_pkt, exp_err;

    vecs[0] = '{12'd0, 1'b0, 64'd0,      16'd40, 64'd1,     4, 0, 0};
    vecs[1] = '{12'd1, 1'b1, 64'h1234,   16'd36, 64'h100,   3, 0, 0};
    vecs[2] = '{12'd2, 1'b0, 64'd0,      16'd8,  64'd0,     0, 0, 1};
    vecs[3] = '{12'd3, 1'b0, 64'd0,      16'd48, 64'h300,   3, 1, 0};
    vecs[4] = '{12'd4, 1'b1, 64'hABCD,   16'd12, 64'd0,     0, 0, 1};
    vecs[5] = '{12'd5, 1'b0, 64'd0,      16'd20, 64'h500,   2, 0, 0};

    i_tdata = 0; i_tlast = 0; i_tvalid = 0;
    reset_n = 1;
    #3 reset_n = 0;
    #20;
    check("rst_i_tready", {63'd0, i_tready}, 64'd1);
    check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    reset_n = 1;
    @(posedge clk); #1;
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_o_length", 64'(o_length), 64'd0);
    check("rst_o_timestamp", o_timestamp, 64'd0);
    check("rst_pulses", 64'({err_len, err_seq, hdr_only}), 64'd0);

    rand_en = 1;
    exp_pkt = 0; exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      l0 = n_len; s0 = n_seq; h0 = n_hdr;
      send_pkt(vecs[i].seq, vecs[i].ht, vecs[i].ts, vecs[i].len, vecs[i].base, vecs[i].npay);
      drain();
      exp_pkt++;
      exp_err += vecs[i].e_len;
      check($sformatf("v%0d_err_len", i), 64'(n_len - l0), 64'(vecs[i].e_len));
      check($sformatf("v%0d_err_seq", i), 64'(n_seq - s0), 64'd0);
      check($sformatf("v%0d_hdr_only", i), 64'(n_hdr - h0), 64'(vecs[i].e_hdr));
      check($sformatf("v%0d_o_length", i), 64'(o_length), 64'(vecs[i].len));
      check($sformatf("v%0d_o_seqnum", i), 64'(o_seqnum), 64'(vecs[i].seq));
      check($sformatf("v%0d_o_sids", i), 64'({o_src_sid, o_dst_sid}), 64'h1234_5678);
      check($sformatf("v%0d_o_timestamp", i), o_timestamp, vecs[i].ht ? vecs[i].ts : 64'd0);
      check($sformatf("v%0d_pkt_count", i), 64'(pkt_count), 64'(exp_pkt));
      check($sformatf("v%0d_err_count", i), 64'(err_count), 64'(exp_err));
    end

    // Seqnum wrap: 4095 is the reference, 0 follows, 2 skips.
    do_reset();
    begin
      logic [11:0] seqs[3];
      int          e_seq[3];
      seqs[0] = 12'd4095; seqs[1] = 12'd0; seqs[2] = 12'd2;
      e_seq[0] = 0; e_seq[1] = 0; e_seq[2] = 1;
      for (int i = 0; i < 3; i++) begin
        s0 = n_seq;
        send_pkt(seqs[i], 1'b0, 64'd0, 16'd24, 64'h700 + 64'(16 * i), 2);
        drain();
        check($sformatf("seq%0d_err_seq", i), 64'(n_seq - s0), 64'(e_seq[i]));
      end
      check("seq_err_count", 64'(err_count), 64'd1);
      check("seq_pkt_count", 64'(pkt_count), 64'd3);
    end

    // Reset in the middle of a payload.
    do_reset();
    send_beat(hdr(12'd10, 1'b0, 16'd40), 1'b0, 1'b0);
    send_beat(64'hA1, 1'b0, 1'b1);
    send_beat(64'hA2, 1'b0, 1'b1);
    drain();
    rand_en = 0;
    o_tready = 0;
    i_tdata = 64'hA3; i_tlast = 0; i_tvalid = 1;
    @(negedge clk);
    check("mid_body_o_tvalid", {63'd0, o_tvalid}, 64'd1);
    check("mid_body_i_tready", {63'd0, i_tready}, 64'd0);
    #2 reset_n = 0;
    #1;
    check("async_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("async_i_tready", {63'd0, i_tready}, 64'd1);
    i_tvalid = 0;
    #15 reset_n = 1;
    @(posedge clk); #1;
    check("post_rst_pkt_count", 64'(pkt_count), 64'd0);
    rand_en = 1;
    l0 = n_len; s0 = n_seq; h0 = n_hdr;
    send_pkt(12'd20, 1'b0, 64'd0, 16'd40, 64'hB0, 4);
    drain();
    check("post_rst_o_length", 64'(o_length), 64'd40);
    check("post_rst_o_seqnum", 64'(o_seqnum), 64'd20);
    check("post_rst_errs", 64'((n_len - l0) + (n_seq - s0) + (n_hdr - h0)), 64'd0);
    check("post_rst_pkt_count1", 64'(pkt_count), 64'd1);
    check("post_rst_err_count", 64'(err_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
